// File: rtl/edge_counter_mc.sv
// Multi-channel edge counter: synchronised inputs, per-channel polarity, request/valid read port.
// Optional compare interrupt enabled by defining EDGE_COUNTER_MC_IRQ_EN.
module edge_counter_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SATURATE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
`ifdef EDGE_COUNTER_MC_IRQ_EN
  input  logic              cmp_we,
  input  logic [CNT_W-1:0]  cmp_data,
`endif
  input  logic              rd_req,
  input  logic [2:0]        rd_ch,
  input  logic              rd_clr,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic              irq
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_last;
  logic [NUM_CH-1:0] hist_q;
  logic [NUM_CH-1:0] rise_v;
  logic [NUM_CH-1:0] fall_v;
  logic [NUM_CH-1:0] edge_inc;
  logic [NUM_CH-1:0] inc_q;
  mode_t             mode_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] cnt_max;
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] cfg_sel;
  logic [NUM_CH-1:0] clr_sel;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_ovf_sel;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise_v    = sync_last & ~hist_q;
  assign fall_v    = ~sync_last & hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
      inc_q  <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_last;
      inc_q  <= edge_inc;
    end
  end

  // Mode is applied at detection, so a same-cycle mode write only affects later edges.
  always_comb begin
    edge_inc = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      case (mode_q[i])
        MODE_RISE: edge_inc[i] = rise_v[i];
        MODE_FALL: edge_inc[i] = fall_v[i];
        MODE_BOTH: edge_inc[i] = rise_v[i] | fall_v[i];
        default:   edge_inc[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    cfg_sel    = '0;
    clr_sel    = '0;
    cnt_max    = '0;
    rd_cnt     = '0;
    rd_ovf_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cfg_sel[i] = cfg_we && (32'(cfg_ch) == i);
      clr_sel[i] = rd_req && rd_clr && (32'(rd_ch) == i);
      cnt_max[i] = &cnt_q[i];
      if (cnt_max[i]) cnt_nxt[i] = (SATURATE != 0) ? cnt_q[i] : '0;
      else            cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
      if (32'(rd_ch) == i) begin
        rd_cnt     = cnt_q[i];
        rd_ovf_sel = ovf_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        mode_q[i] <= MODE_OFF;
      end
      ovf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        // A clear coinciding with a countable edge restarts at 1 so the edge is kept.
        if (clr_sel[i]) begin
          cnt_q[i] <= inc_q[i] ? CNT_W'(1) : '0;
          ovf_q[i] <= 1'b0;
        end else if (inc_q[i]) begin
          cnt_q[i] <= cnt_nxt[i];
          if (cnt_max[i]) ovf_q[i] <= 1'b1;
        end
        if (cfg_sel[i]) mode_q[i] <= mode_t'(cfg_mode);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_cnt;
        rd_ovf  <= rd_ovf_sel;
      end
    end
  end

`ifdef EDGE_COUNTER_MC_IRQ_EN
  logic [CNT_W-1:0]  cmp_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cmp_q[i] <= '1;
      pend_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cmp_we && (32'(cfg_ch) == i)) cmp_q[i] <= cmp_data;
        if (clr_sel[i]) begin
          pend_q[i] <= inc_q[i] && (cmp_q[i] == CNT_W'(1));
        end else if (inc_q[i] && (cnt_nxt[i] != cnt_q[i]) && (cnt_nxt[i] == cmp_q[i])) begin
          pend_q[i] <= 1'b1;
        end
      end
    end
  end

  assign irq = |pend_q;
`else
  assign irq = 1'b0;
`endif

endmodule
